// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch front end.
//   INST_W        instruction word width
//   PC_INC        PC step per sequential fetch
//   RV_NOP        canonical rv32 NOP (addi x0,x0,0)
//   fetch_entry_t {pc, inst} pair as handed to decode (32-bit PC build)
package fetch_pkg;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned PC_INC     = 4;
  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam int unsigned FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INST_W-1:0]     inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data
//   pop, rdata    read request; rdata shows the head entry
//   flush         empties the FIFO (push/pop ignored that cycle)
//   count         current occupancy
//   full, empty   occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  // A pop frees the slot in the same cycle, so push is legal even when full.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rv32 instruction-fetch front end.
//   clk, rst                      clock, synchronous active-high reset
//   fetch_en                      permits issuing new imem requests
//   jump_valid/jump_target        jump redirect (wins over branch)
//   branch_valid/branch_target    taken-branch redirect
//   imem_req_valid/addr/ready     in-order request channel to imem (addr = pc)
//   imem_rsp_valid/data           in-order response channel, always accepted
//   inst_valid/pc/data/ready      {pc, instruction} handshake to decode
//   pc                            next fetch address
// Requests are credit-limited so that buffered plus in-flight never exceeds
// FIFO_DEPTH; on redirect, responses to stale requests are counted off via
// drop_cnt and discarded.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              jump_valid,
  input  logic [XLEN-1:0]   jump_target,
  input  logic              branch_valid,
  input  logic [XLEN-1:0]   branch_target,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [XLEN-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   pc
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            redirect;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  entry_t          wr_entry;
  entry_t          head;

  assign redirect = jump_valid | branch_valid;
  assign target   = jump_valid ? {jump_target[XLEN-1:2], 2'b00}
                               : {branch_target[XLEN-1:2], 2'b00};

  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = ~rst & fetch_en & ~redirect & ~fifo_full
                        & (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign push     = imem_rsp_valid & ~redirect & (drop_cnt == '0);
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign wr_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign inst_valid = ~fifo_empty;
  assign inst_pc    = inst_valid ? head.pc   : '0;
  assign inst_data  = inst_valid ? head.inst : '0;

  sync_fifo #(
    .WIDTH (XLEN + INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        pc       <= target;
        rsp_pc   <= target;
        // A response landing this cycle retires one stale request already.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc     <= pc + XLEN'(PC_INC);
        if (push)     rsp_pc <= rsp_pc + XLEN'(PC_INC);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .jump_valid     (jump_valid),
    .jump_target    (jump_target),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready),
    .pc             (pc)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        fe, rdy, ir, jv, bv, rv;
    logic [31:0] jt, bt, ra;
    logic        er;
    logic [31:0] ea;
    logic        ei;
    logic [31:0] ep;
  } vec_t;

  function automatic vec_t v(input logic fe, rdy, ir, jv, input logic [31:0] jt,
                             input logic bv, input logic [31:0] bt,
                             input logic rv, input logic [31:0] ra,
                             input logic er, input logic [31:0] ea,
                             input logic ei, input logic [31:0] ep);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.ir = ir; r.jv = jv; r.jt = jt; r.bv = bv; r.bt = bt;
    r.rv = rv; r.ra = ra; r.er = er; r.ea = ea; r.ei = ei; r.ep = ep;
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        imq[$];
  int unsigned cyc_n, last_due, lat_min = 1, lat_max = 1;
  logic [31:0] exp_req, exp_dec, first_dec_pc;
  int          n_dec, n_req, tot_dec, first_req_c, first_iv_c;
  logic        k_fe, k_rdy, k_ir, k_jv, k_bv;
  logic [31:0] k_jt, k_bt;

  task automatic do_reset(input int unsigned n);
    rst = 1'b1; fetch_en = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    jump_valid = 1'b0; branch_valid = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    imq.delete();
    last_due = 0; cyc_n = 0; exp_req = RV; exp_dec = RV;
    n_dec = 0; n_req = 0; first_req_c = -1; first_iv_c = -1;
    first_dec_pc = 32'hFFFF_FFFF;
  endtask

  // One clock cycle driven by the knobs; imem is modelled as an in-order
  // queue with a per-request latency, decode expectations follow the
  // architectural PC stream (target, target+4, ...).
  task automatic cyc();
    logic        redir;
    logic [31:0] tgt;
    int unsigned lat, due;
    fetch_en = k_fe; imem_req_ready = k_rdy; inst_ready = k_ir;
    jump_valid = k_jv; jump_target = k_jt; branch_valid = k_bv; branch_target = k_bt;
    if (imq.size() > 0 && imq[0].due <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(imq[0].addr);
      void'(imq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    redir = k_jv | k_bv;
    tgt   = k_jv ? k_jt : k_bt;
    tgt[1:0] = 2'b00;
    if (redir) check("req_during_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid && k_rdy) begin
      check("req_addr", imem_req_addr, exp_req);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc_n + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      imq.push_back('{addr: imem_req_addr, due: due});
      check("credit_in_flight", 32'(imq.size() <= DEPTH), 32'd1);
      if (first_req_c < 0) first_req_c = int'(cyc_n);
      n_req++;
      exp_req = exp_req + 32'd4;
    end
    if (inst_valid && first_iv_c < 0) first_iv_c = int'(cyc_n);
    if (inst_valid && k_ir && !redir) begin
      check("dec_pc", inst_pc, exp_dec);
      check("dec_data", inst_data, memf(exp_dec));
      if (n_dec == 0) first_dec_pc = inst_pc;
      exp_dec = exp_dec + 32'd4;
      n_dec++;
      tot_dec++;
    end
    if (redir) begin
      exp_req = tgt;
      exp_dec = tgt;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    vec_t tv[22];
    k_fe = 0; k_rdy = 0; k_ir = 0; k_jv = 0; k_bv = 0; k_jt = '0; k_bt = '0;
    tot_dec = 0;

    // Reset state
    do_reset(2);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_pc", pc, RV);

    // Directed table: fill to 4 credits, single pop frees one request,
    // jump-over-branch with coincident response, redirect dropping a stale
    // response while two are outstanding, target low bits forced to zero.
    //            fe rdy ir jv jt          bv bt          rv ra           er ea           ei ep
    tv[0]  = v(1, 1, 0, 0, 0,          0, 0,          0, 0,          1, 32'h0,     0, 0);
    tv[1]  = v(1, 1, 0, 0, 0,          0, 0,          1, 32'h0,      1, 32'h4,     0, 0);
    tv[2]  = v(1, 1, 0, 0, 0,          0, 0,          1, 32'h4,      1, 32'h8,     1, 32'h0);
    tv[3]  = v(1, 1, 0, 0, 0,          0, 0,          1, 32'h8,      1, 32'hC,     1, 32'h0);
    tv[4]  = v(1, 1, 0, 0, 0,          0, 0,          1, 32'hC,      0, 32'h10,    1, 32'h0);
    tv[5]  = v(1, 1, 0, 0, 0,          0, 0,          0, 0,          0, 32'h10,    1, 32'h0);
    tv[6]  = v(1, 1, 1, 0, 0,          0, 0,          0, 0,          0, 32'h10,    1, 32'h0);
    tv[7]  = v(1, 1, 0, 0, 0,          0, 0,          0, 0,          1, 32'h10,    1, 32'h4);
    tv[8]  = v(1, 1, 0, 0, 0,          0, 0,          0, 0,          0, 32'h14,    1, 32'h4);
    tv[9]  = v(1, 1, 1, 1, 32'h200,    1, 32'h300,    1, 32'h10,     0, 32'h14,    1, 32'h4);
    tv[10] = v(1, 1, 1, 0, 0,          0, 0,          0, 0,          1, 32'h200,   0, 0);
    tv[11] = v(1, 0, 1, 0, 0,          0, 0,          1, 32'h200,    1, 32'h204,   0, 0);
    tv[12] = v(1, 0, 1, 0, 0,          0, 0,          0, 0,          1, 32'h204,   1, 32'h200);
    tv[13] = v(0, 1, 1, 0, 0,          0, 0,          0, 0,          0, 32'h204,   0, 0);
    tv[14] = v(1, 1, 1, 0, 0,          0, 0,          0, 0,          1, 32'h204,   0, 0);
    tv[15] = v(1, 1, 1, 0, 0,          0, 0,          0, 0,          1, 32'h208,   0, 0);
    tv[16] = v(1, 1, 1, 0, 0,          1, 32'h103,    1, 32'h204,    0, 32'h20C,   0, 0);
    tv[17] = v(0, 1, 1, 0, 0,          0, 0,          1, 32'h208,    0, 32'h100,   0, 0);
    tv[18] = v(1, 1, 1, 0, 0,          0, 0,          0, 0,          1, 32'h100,   0, 0);
    tv[19] = v(0, 1, 1, 0, 0,          0, 0,          1, 32'h100,    0, 32'h104,   0, 0);
    tv[20] = v(0, 1, 1, 0, 0,          0, 0,          0, 0,          0, 32'h104,   1, 32'h100);
    tv[21] = v(0, 1, 1, 0, 0,          0, 0,          0, 0,          0, 32'h104,   0, 0);
    for (int i = 0; i < 22; i++) begin
      fetch_en = tv[i].fe; imem_req_ready = tv[i].rdy; inst_ready = tv[i].ir;
      jump_valid = tv[i].jv; jump_target = tv[i].jt;
      branch_valid = tv[i].bv; branch_target = tv[i].bt;
      imem_rsp_valid = tv[i].rv;
      imem_rsp_data  = tv[i].rv ? memf(tv[i].ra) : '0;
      @(negedge clk);
      check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tv[i].er));
      check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tv[i].ea);
      check($sformatf("tbl%0d_pc", i), pc, tv[i].ea);
      check($sformatf("tbl%0d_inst_valid", i), 32'(inst_valid), 32'(tv[i].ei));
      check($sformatf("tbl%0d_inst_pc", i), inst_pc, tv[i].ep);
      check($sformatf("tbl%0d_inst_data", i), inst_data, tv[i].ei ? memf(tv[i].ep) : 32'd0);
      @(posedge clk);
      #1;
    end

    // Streaming with 1-cycle imem
    do_reset(1);
    lat_min = 1; lat_max = 1;
    k_fe = 1; k_rdy = 1; k_ir = 1; k_jv = 0; k_bv = 0;
    repeat (10) cyc();
    check("stream_first_latency", 32'(first_iv_c - first_req_c), 32'd2);
    check("stream_decode_count", 32'(n_dec), 32'd8);

    // Branch with three requests in flight on a 4-cycle imem
    do_reset(1);
    lat_min = 4; lat_max = 4;
    k_fe = 1; k_rdy = 1; k_ir = 1;
    repeat (3) cyc();
    k_bv = 1; k_bt = 32'h100;
    cyc();
    k_bv = 0;
    repeat (14) cyc();
    check("branch_first_dec_pc", first_dec_pc, 32'h100);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    k_jv = 1; k_jt = 32'hFFFF_FFFC;
    cyc();
    k_jv = 0;
    cyc();
    check("pc_wrap", pc, 32'h0);
    k_fe = 0;
    repeat (6) cyc();
    k_fe = 1;
    repeat (3) cyc();

    // Reset mid-stream
    do_reset(1);
    check("midrst_pc", pc, RV);
    check("midrst_inst_valid", 32'(inst_valid), 32'd0);

    // Randomised traffic
    lat_min = 1; lat_max = 5;
    for (int n = 0; n < 3000; n++) begin
      k_fe  = ($urandom_range(9, 0) != 0);
      k_rdy = ($urandom_range(3, 0) != 0);
      k_ir  = ($urandom_range(2, 0) != 0);
      k_jv  = ($urandom_range(29, 0) == 0);
      k_bv  = ($urandom_range(19, 0) == 0);
      k_jt  = $urandom();
      k_bt  = $urandom();
      if ($urandom_range(599, 0) == 0) do_reset($urandom_range(2, 1));
      else cyc();
    end
    check("random_liveness", 32'(tot_dec >= 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
